// File: rtl/connect_arb_pkg.sv
// Shared arbitration types and credit-counter sizing for the flit send arbiter.
// Build-time defaults for flit width and per-VC buffer depth.
// No logic of its own, so no latency or backpressure.
`ifndef FLIT_WIDTH
`define FLIT_WIDTH 32
`endif
`ifndef FLIT_BUFFER_DEPTH
`define FLIT_BUFFER_DEPTH 4
`endif

package connect_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // A counter must hold the value DEPTH itself, not just DEPTH-1.
    function automatic int credit_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: one-hot grant of the first request found after ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; an empty request vector gives an all-zero grant.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt
);

    int idx;

    // Walk from the farthest slot to the nearest so the nearest hit wins.
    always_comb begin
        gnt = '0;
        idx = 0;
        for (int off = N; off >= 1; off--) begin
            idx = (int'(ptr) + off) % N;
            if (req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/flit_send_arbiter.sv
// Packet-atomic round-robin arbiter of NUM_REQ requesters onto one credited send port.
// Latency: 1 cycle from transfer (valid&&ready) to registered flit/enable.
// Backpressure: ready only for a requester whose VC has credit; optional counters under FLIT_ARB_STATS_EN.
module flit_send_arbiter
    import connect_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int NUM_VCS = 2,
    parameter int FLIT_W  = `FLIT_WIDTH,
    parameter int DEPTH   = `FLIT_BUFFER_DEPTH,
    localparam int VC_BITS = $clog2(NUM_VCS)
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic [NUM_REQ*FLIT_W-1:0]    req_flit,
    input  logic [NUM_REQ*VC_BITS-1:0]   req_vc,
    input  logic [NUM_REQ-1:0]           req_last,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [FLIT_W-1:0]            send_ports_putFlit_flit_in,
    output logic                         EN_send_ports_putFlit,
    input  logic [VC_BITS:0]             send_ports_getCredits,
    output logic                         EN_send_ports_getCredits,
    output logic                         err_credit_ovf,
    output logic [NUM_REQ*16-1:0]        stat_grants,
    output logic [15:0]                  stat_stalls
);

    localparam int CRED_W = credit_width(DEPTH);
    localparam int REQ_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t         state_q, state_d;
    logic [REQ_W-1:0]   owner_q, owner_d;
    logic [REQ_W-1:0]   last_grant_q, last_grant_d;
    logic [VC_BITS-1:0] vc_q, vc_d;
    logic [CRED_W-1:0]  cred_q [NUM_VCS];
    logic [CRED_W-1:0]  cred_d [NUM_VCS];
    logic [FLIT_W-1:0]  flit_q, flit_d;
    logic               en_q, en_d;
    logic               ovf_q, ovf_d;

    logic [VC_BITS-1:0] req_vc_a [NUM_REQ];
    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] arb_req;
    logic [NUM_REQ-1:0] gnt;
    logic               own_elig;
    logic               xfer;
    logic [REQ_W-1:0]   g;
    logic [VC_BITS-1:0] g_vc;
    logic [FLIT_W-1:0]  g_flit;
    logic               ret_vld;
    logic [VC_BITS-1:0] ret_vc;

    assign EN_send_ports_getCredits   = 1'b1;
    assign send_ports_putFlit_flit_in = flit_q;
    assign EN_send_ports_putFlit      = en_q;
    assign err_credit_ovf             = ovf_q;
    assign ret_vld                    = send_ports_getCredits[VC_BITS];
    assign ret_vc                     = send_ports_getCredits[VC_BITS-1:0];

    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_vc_a[i] = req_vc[i*VC_BITS +: VC_BITS];
            elig[i]     = req_valid[i] && (int'(req_vc_a[i]) < NUM_VCS)
                          && (cred_q[req_vc_a[i]] != '0);
        end
    end

    // While locked the owner is judged against the VC captured at the packet head.
    assign own_elig = req_valid[owner_q] && (cred_q[vc_q] != '0);
    assign arb_req  = (state_q == LOCKED) ? (own_elig ? (NUM_REQ'(1) << owner_q) : '0)
                                          : elig;

    rr_arbiter #(
        .N     (NUM_REQ),
        .PTR_W (REQ_W)
    ) u_rr (
        .req (arb_req),
        .ptr (last_grant_q),
        .gnt (gnt)
    );

    // The grant is combinational on live state, so it must be masked while reset is low.
    assign req_ready = RST_N ? gnt : '0;
    assign xfer      = |req_ready;

    always_comb begin
        g = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) g = REQ_W'(i);
        end
    end

    assign g_vc   = (state_q == LOCKED) ? vc_q : req_vc_a[g];
    assign g_flit = req_flit[g*FLIT_W +: FLIT_W];

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        vc_d         = vc_q;
        last_grant_d = last_grant_q;
        flit_d       = '0;
        en_d         = 1'b0;
        if (xfer) begin
            en_d         = 1'b1;
            flit_d       = g_flit | {1'b1, {(FLIT_W-1){1'b0}}};
            last_grant_d = g;
            if (state_q == IDLE && !req_last[g]) begin
                state_d = LOCKED;
                owner_d = g;
                vc_d    = g_vc;
            end else if (state_q == LOCKED && req_last[g]) begin
                state_d = IDLE;
            end
        end
    end

    always_comb begin
        ovf_d = ovf_q;
        for (int v = 0; v < NUM_VCS; v++) begin
            cred_d[v] = cred_q[v];
            if (xfer && g_vc == VC_BITS'(v) && !(ret_vld && ret_vc == VC_BITS'(v))) begin
                cred_d[v] = cred_q[v] - 1'b1;
            end else if (ret_vld && ret_vc == VC_BITS'(v) && !(xfer && g_vc == VC_BITS'(v))) begin
                if (cred_q[v] == CRED_W'(DEPTH)) ovf_d = 1'b1;
                else                             cred_d[v] = cred_q[v] + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            vc_q         <= '0;
            last_grant_q <= REQ_W'(NUM_REQ - 1);
            flit_q       <= '0;
            en_q         <= 1'b0;
            ovf_q        <= 1'b0;
            for (int v = 0; v < NUM_VCS; v++) cred_q[v] <= CRED_W'(DEPTH);
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            vc_q         <= vc_d;
            last_grant_q <= last_grant_d;
            flit_q       <= flit_d;
            en_q         <= en_d;
            ovf_q        <= ovf_d;
            for (int v = 0; v < NUM_VCS; v++) cred_q[v] <= cred_d[v];
        end
    end

`ifdef FLIT_ARB_STATS_EN
    logic [15:0] grants_q [NUM_REQ];
    logic [15:0] grants_d [NUM_REQ];
    logic [15:0] stalls_q, stalls_d;

    always_comb begin
        stalls_d = stalls_q + 16'((|req_valid) && !xfer);
        for (int i = 0; i < NUM_REQ; i++) begin
            grants_d[i] = grants_q[i] + 16'(req_ready[i]);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            stalls_q <= '0;
            for (int i = 0; i < NUM_REQ; i++) grants_q[i] <= '0;
        end else begin
            stalls_q <= stalls_d;
            for (int i = 0; i < NUM_REQ; i++) grants_q[i] <= grants_d[i];
        end
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stat_pack
        assign stat_grants[gi*16 +: 16] = grants_q[gi];
    end
    assign stat_stalls = stalls_q;
`else
    assign stat_grants = '0;
    assign stat_stalls = '0;
`endif

endmodule
